// File: rtl/keep_fifo_unpacker_pkg.sv
// Lane-search helpers shared by the keep FIFO unpacker.
// Keep vectors are zero-extended to MAX_RATIO so one function body serves every lane count.
package keep_fifo_unpacker_pkg;

   localparam int MAX_RATIO = 32;

   function automatic bit ratio_ok(input int ratio);
      return (ratio >= 2) && (ratio <= MAX_RATIO);
   endfunction

   // Returns -1 when no lane is kept.
   function automatic int lowest_set(input logic [MAX_RATIO-1:0] keep);
      int r;
      r = -1;
      for (int k = MAX_RATIO - 1; k >= 0; k--) begin
         if (keep[k]) r = k;
      end
      return r;
   endfunction

   // Returns -1 when no kept lane lies above idx.
   function automatic int next_set_above(input logic [MAX_RATIO-1:0] keep, input int idx);
      int r;
      r = -1;
      for (int k = MAX_RATIO - 1; k >= 0; k--) begin
         if (keep[k] && (k > idx)) r = k;
      end
      return r;
   endfunction

endpackage

// File: rtl/keep_fifo_unpacker_if.sv
// FIFO read port plus narrow AXI-Stream master of the keep FIFO unpacker.
// master = the environment (FIFO and downstream sink), slave = the unpacker itself.
interface keep_fifo_unpacker_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 2
);
    logic                                 fifo_empty;
    logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] fifo_data;
    logic [T_DATA_RATIO-1:0]              fifo_keep;
    logic                                 fifo_last;
    logic                                 fifo_pop;
    logic [T_DATA_WIDTH-1:0]              m_data;
    logic                                 m_last;
    logic                                 m_valid;
    logic                                 m_ready;
    logic                                 err;

    modport master (
        output fifo_empty, fifo_data, fifo_keep, fifo_last, m_ready,
        input  fifo_pop, m_data, m_last, m_valid, err
    );

    modport slave (
        input  fifo_empty, fifo_data, fifo_keep, fifo_last, m_ready,
        output fifo_pop, m_data, m_last, m_valid, err
    );
endinterface

// File: rtl/keep_fifo_unpacker_lane_find.sv
// Priority encoder: lowest kept lane (from_start=1) or next kept lane above idx.
module lane_find_next
    import keep_fifo_unpacker_pkg::*;
#(
    parameter  int RATIO = 2,
    localparam int IDX_W = $clog2(RATIO)
) (
    input  logic [RATIO-1:0] keep,
    input  logic [IDX_W-1:0] idx,
    input  logic             from_start,
    output logic [IDX_W-1:0] next_idx,
    output logic             found
);
    always_comb begin
        int pos;
        pos = from_start ? lowest_set(MAX_RATIO'(keep))
                         : next_set_above(MAX_RATIO'(keep), int'(idx));
        found    = (pos >= 0);
        next_idx = found ? IDX_W'(pos) : '0;
    end
endmodule

// File: rtl/keep_fifo_unpacker.sv
// Pops wide words from a show-ahead keep FIFO and emits one narrow beat per kept lane,
// ascending lane order; keep=0 words are dropped and flagged on a sticky error.
module keep_fifo_unpacker
    import keep_fifo_unpacker_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keep_fifo_unpacker_if.slave  bus
);
    localparam int IDX_W = $clog2(T_DATA_RATIO);
    typedef logic [IDX_W-1:0] lane_idx_t;

    if (!ratio_ok(T_DATA_RATIO)) begin : g_bad_ratio
        $error("keep_fifo_unpacker: T_DATA_RATIO must be in 2..MAX_RATIO");
    end

    logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] hold_data;
    logic [T_DATA_RATIO-1:0]              hold_keep;
    logic                                 hold_last;
    logic                                 hold_valid;
    lane_idx_t                            lane_idx;
    logic                                 err_q;

    lane_idx_t load_idx;
    lane_idx_t adv_idx;
    logic      load_found;
    logic      adv_found;
    logic      final_lane;
    logic      xfer;
    logic      pop;

    lane_find_next #(.RATIO(T_DATA_RATIO)) u_find_load (
        .keep       (bus.fifo_keep),
        .idx        ('0),
        .from_start (1'b1),
        .next_idx   (load_idx),
        .found      (load_found)
    );

    lane_find_next #(.RATIO(T_DATA_RATIO)) u_find_adv (
        .keep       (hold_keep),
        .idx        (lane_idx),
        .from_start (1'b0),
        .next_idx   (adv_idx),
        .found      (adv_found)
    );

    assign final_lane = ~adv_found;
    assign xfer       = hold_valid & bus.m_ready;
    // rst_n gates the pop so the FIFO is never advanced while this block is held in reset.
    assign pop        = rst_n & ~bus.fifo_empty & (~hold_valid | (bus.m_ready & final_lane));

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = hold_valid;
    assign bus.m_data   = hold_data[lane_idx*T_DATA_WIDTH +: T_DATA_WIDTH];
    assign bus.m_last   = hold_valid & hold_last & final_lane;
    assign bus.err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            lane_idx   <= '0;
            err_q      <= 1'b0;
        end else if (pop) begin
            if (load_found) begin
                hold_data  <= bus.fifo_data;
                hold_keep  <= bus.fifo_keep;
                hold_last  <= bus.fifo_last;
                hold_valid <= 1'b1;
                lane_idx   <= load_idx;
            end else begin
                // Empty-keep word carries no beat, so its last marker is lost.
                hold_valid <= 1'b0;
                err_q      <= 1'b1;
            end
        end else if (xfer) begin
            if (final_lane) hold_valid <= 1'b0;
            else            lane_idx   <= adv_idx;
        end
    end
endmodule

// File: tb/tb_keep_fifo_unpacker.sv
// Bench for keep_fifo_unpacker: RATIO=2 and RATIO=4 instances fed from queue-modelled FIFOs.
module tb_keep_fifo_unpacker;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          n;
      logic [7:0]  first_d;
      logic [7:0]  final_d;
      logic        final_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   keep_fifo_unpacker_if #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) bus2 ();
   keep_fifo_unpacker_if #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) bus4 ();

   keep_fifo_unpacker #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   keep_fifo_unpacker #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   word_t q2[$], q4[$];
   beat_t out2[$], out4[$];
   beat_t exp2[$], exp4[$];
   int    popc2[$], beatc2[$];
   logic  exp_err4 = 1'b0;

   logic  stall2 = 1'b0, stall4 = 1'b0;
   logic [7:0] sd2, sd4;
   logic  sl2, sl4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: one beat per kept lane, ascending; last only on the highest kept lane.
   function automatic void model(input word_t w, input int ratio);
      beat_t b;
      if (w.keep == 4'd0 && ratio == 4) exp_err4 = 1'b1;
      for (int k = 0; k < ratio; k++) begin
         if (w.keep[k]) begin
            b.data = w.data[8*k +: 8];
            b.last = w.last && ((w.keep >> (k + 1)) == 4'd0);
            if (ratio == 2) exp2.push_back(b);
            else            exp4.push_back(b);
         end
      end
   endfunction

   task automatic drive_fifo();
      bus2.fifo_empty = (q2.size() == 0);
      bus4.fifo_empty = (q4.size() == 0);
      bus2.fifo_data = '0; bus2.fifo_keep = '0; bus2.fifo_last = 1'b0;
      bus4.fifo_data = '0; bus4.fifo_keep = '0; bus4.fifo_last = 1'b0;
      if (q2.size() != 0) begin
         bus2.fifo_data = q2[0].data[15:0];
         bus2.fifo_keep = q2[0].keep[1:0];
         bus2.fifo_last = q2[0].last;
      end
      if (q4.size() != 0) begin
         bus4.fifo_data = q4[0].data;
         bus4.fifo_keep = q4[0].keep;
         bus4.fifo_last = q4[0].last;
      end
   endtask

   task automatic cycle();
      logic p2, p4, x2, x4;
      beat_t b2, b4;
      drive_fifo();
      #1;
      if (rst_n) begin
         if (stall2) begin
            chk("stall_valid2", bus2.m_valid, 1);
            chk("stall_data2", bus2.m_data, sd2);
            chk("stall_last2", bus2.m_last, sl2);
         end
         if (stall4) begin
            chk("stall_valid4", bus4.m_valid, 1);
            chk("stall_data4", bus4.m_data, sd4);
            chk("stall_last4", bus4.m_last, sl4);
         end
         stall2 = bus2.m_valid && !bus2.m_ready; sd2 = bus2.m_data; sl2 = bus2.m_last;
         stall4 = bus4.m_valid && !bus4.m_ready; sd4 = bus4.m_data; sl4 = bus4.m_last;
      end else begin
         stall2 = 1'b0;
         stall4 = 1'b0;
      end
      if (bus2.fifo_empty) chk("pop_when_empty2", bus2.fifo_pop, 0);
      if (bus4.fifo_empty) chk("pop_when_empty4", bus4.fifo_pop, 0);
      p2 = bus2.fifo_pop;
      p4 = bus4.fifo_pop;
      x2 = bus2.m_valid && bus2.m_ready;
      x4 = bus4.m_valid && bus4.m_ready;
      b2 = '{bus2.m_data, bus2.m_last};
      b4 = '{bus4.m_data, bus4.m_last};
      @(posedge clk);
      if (p2 && q2.size() != 0) begin void'(q2.pop_front()); popc2.push_back(cyc); end
      if (p4 && q4.size() != 0) void'(q4.pop_front());
      if (x2) begin out2.push_back(b2); beatc2.push_back(cyc); end
      if (x4) out4.push_back(b4);
      cyc++;
      #1;
      drive_fifo();
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((q2.size() != 0 || bus2.m_valid || q4.size() != 0 || bus4.m_valid) && n < budget) begin
         cycle();
         n++;
      end
      chk(name, (q2.size() != 0 || bus2.m_valid || q4.size() != 0 || bus4.m_valid), 0);
   endtask

   task automatic compare_out(input string name, input int ratio);
      int ne, no;
      ne = (ratio == 2) ? exp2.size() : exp4.size();
      no = (ratio == 2) ? out2.size() : out4.size();
      chk({name, "_count"}, no, ne);
      for (int i = 0; i < ne && i < no; i++) begin
         if (ratio == 2) begin
            chk({name, "_data"}, out2[i].data, exp2[i].data);
            chk({name, "_last"}, out2[i].last, exp2[i].last);
         end else begin
            chk({name, "_data"}, out4[i].data, exp4[i].data);
            chk({name, "_last"}, out4[i].last, exp4[i].last);
         end
      end
   endtask

   task automatic push2(input logic [15:0] d, input logic [1:0] k, input logic l);
      word_t w;
      w = '{{16'h0, d}, {2'b00, k}, l};
      q2.push_back(w);
      model(w, 2);
   endtask

   vec_t vecs[6];

   initial begin
      word_t w;
      int sent, budget;

      vecs[0] = '{32'hDDCCBBAA, 4'b1010, 1'b1, 2, 8'hBB, 8'hDD, 1'b1};
      vecs[1] = '{32'h44332211, 4'b1111, 1'b0, 4, 8'h11, 8'h44, 1'b0};
      vecs[2] = '{32'h44332211, 4'b0001, 1'b1, 1, 8'h11, 8'h11, 1'b1};
      vecs[3] = '{32'h44332211, 4'b1000, 1'b1, 1, 8'h44, 8'h44, 1'b1};
      vecs[4] = '{32'h88776655, 4'b0110, 1'b1, 2, 8'h66, 8'h77, 1'b1};
      vecs[5] = '{32'h88776655, 4'b1001, 1'b0, 2, 8'h55, 8'h88, 1'b0};

      bus2.m_ready = 1'b0;
      bus4.m_ready = 1'b0;
      drive_fifo();

      // Reset values
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid2", bus2.m_valid, 0);
      chk("rst_last2", bus2.m_last, 0);
      chk("rst_pop2", bus2.fifo_pop, 0);
      chk("rst_err2", bus2.err, 0);
      chk("rst_data2", bus2.m_data, 0);
      chk("rst_valid4", bus4.m_valid, 0);
      chk("rst_data4", bus4.m_data, 0);
      rst_n = 1'b1;
      cycle();

      // Full keep, RATIO=2, with one-cycle load latency
      out2.delete(); exp2.delete(); popc2.delete();
      push2(16'hBBAA, 2'b11, 1'b1);
      bus2.m_ready = 1'b1;
      cycle();
      chk("full_latency_valid", bus2.m_valid, 1);
      chk("full_first_data", bus2.m_data, 8'hAA);
      drain("full_timeout", 20);
      compare_out("full", 2);
      chk("full_pops", popc2.size(), 1);

      // Table of single words on RATIO=4
      bus4.m_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         out4.delete();
         w = '{vecs[v].data, vecs[v].keep, vecs[v].last};
         q4.push_back(w);
         drain("vec_timeout", 20);
         chk("vec_count", out4.size(), vecs[v].n);
         if (out4.size() != 0) begin
            chk("vec_first", out4[0].data, vecs[v].first_d);
            chk("vec_final", out4[out4.size()-1].data, vecs[v].final_d);
            chk("vec_final_last", out4[out4.size()-1].last, vecs[v].final_last);
            for (int i = 0; i + 1 < out4.size(); i++) chk("vec_mid_last", out4[i].last, 0);
         end
      end

      // Backpressure on beat AA
      out2.delete(); exp2.delete();
      push2(16'hBBAA, 2'b11, 1'b1);
      push2(16'hCCDD, 2'b11, 1'b1);
      bus2.m_ready = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", bus2.m_valid, 1);
         chk("bp_data", bus2.m_data, 8'hAA);
         chk("bp_pop", bus2.fifo_pop, 0);
         cycle();
      end
      bus2.m_ready = 1'b1;
      drain("bp_timeout", 20);
      compare_out("bp", 2);

      // Throughput: three full words back to back
      out2.delete(); exp2.delete(); popc2.delete(); beatc2.delete();
      push2(16'h2211, 2'b11, 1'b0);
      push2(16'h4433, 2'b11, 1'b0);
      push2(16'h6655, 2'b11, 1'b1);
      drain("tp_timeout", 20);
      compare_out("tp", 2);
      chk("tp_pop_count", popc2.size(), 3);
      chk("tp_beat_count", beatc2.size(), 6);
      if (popc2.size() == 3 && beatc2.size() == 6) begin
         for (int i = 0; i < 3; i++) chk("tp_pop_cycle", popc2[i] - popc2[0], 2 * i);
         for (int i = 0; i < 6; i++) chk("tp_beat_cycle", beatc2[i] - popc2[0], i + 1);
      end

      // Empty-keep word between two valid words
      out2.delete(); exp2.delete(); popc2.delete();
      push2(16'h2211, 2'b11, 1'b1);
      push2(16'h9999, 2'b00, 1'b1);
      push2(16'h4433, 2'b11, 1'b1);
      cycle();
      chk("err_before", bus2.err, 0);
      drain("err_timeout", 20);
      compare_out("err", 2);
      chk("err_pops", popc2.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("err_sticky", bus2.err, 1);
         cycle();
      end

      // Random stream on RATIO=4 against the reference model
      out4.delete(); exp4.delete();
      sent = 0;
      budget = 0;
      while ((sent < 200 || q4.size() != 0 || bus4.m_valid) && budget < 6000) begin
         if (sent < 200 && $urandom_range(0, 2) != 0) begin
            w.data = $urandom;
            w.keep = 4'($urandom_range(0, 15));
            w.last = 1'($urandom_range(0, 1));
            q4.push_back(w);
            model(w, 4);
            sent++;
         end
         bus4.m_ready = ($urandom_range(0, 3) != 0);
         cycle();
         budget++;
      end
      chk("rand_timeout", budget < 6000, 1);
      compare_out("rand", 4);
      chk("rand_err", bus4.err, exp_err4);

      // Reset mid-packet with the FIFO still holding a word
      out2.delete(); exp2.delete();
      push2(16'hBBAA, 2'b11, 1'b1);
      q2.push_back('{32'h0000DDCC, 4'b0011, 1'b1});
      bus2.m_ready = 1'b0;
      cycle();
      chk("mid_pkt_valid", bus2.m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus2.m_valid, 0);
      chk("mid_rst_pop", bus2.fifo_pop, 0);
      chk("mid_rst_err", bus2.err, 0);
      chk("mid_rst_last", bus2.m_last, 0);
      cycle();
      cycle();
      chk("mid_rst_fifo_kept", q2.size(), 1);
      exp2.delete();
      exp2.push_back('{8'hCC, 1'b0});
      exp2.push_back('{8'hDD, 1'b1});
      rst_n = 1'b1;
      bus2.m_ready = 1'b1;
      cycle();
      chk("rel_valid", bus2.m_valid, 1);
      chk("rel_data", bus2.m_data, 8'hCC);
      drain("rel_timeout", 20);
      compare_out("rel", 2);
      chk("rel_err", bus2.err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
